// File: rtl/dvi_pkg.sv
// Shared types and constants for the DVI frame-capture sequencer.
// Imported by the capture controller and its sync-edge detector.
package dvi_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        DROP    = 2'd3
    } cap_state_t;

    localparam int DW_DEF = 24;
    localparam int CW_DEF = 12;

    localparam logic VS_LVL_LOW  = 1'b0;
    localparam logic VS_LVL_HIGH = 1'b1;

endpackage

// File: rtl/dvi_sync_edge.sv
// Registers vsync/de on the pixel strobe and flags frame start,
// frame end and the falling edge of data enable.
module dvi_sync_edge
    import dvi_pkg::*;
#(
    parameter logic VS_PULSE_LVL = VS_LVL_LOW
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pix_en,
    input  logic vsync,
    input  logic de,
    output logic fs,
    output logic fe,
    output logic de_fall
);

    logic vsync_q;
    logic de_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vsync_q <= 1'b0;
            de_q    <= 1'b0;
        end else if (pix_en) begin
            vsync_q <= vsync;
            de_q    <= de;
        end
    end

    assign fs = pix_en && (vsync_q == VS_PULSE_LVL)
                && (vsync != VS_PULSE_LVL);
    assign fe = pix_en && (vsync_q != VS_PULSE_LVL)
                && (vsync == VS_PULSE_LVL);
    assign de_fall = pix_en && de_q && !de;

endmodule

// File: rtl/dvi_capture_ctrl.sv
// Frame-capture sequencer: arms on request, aligns to a frame start,
// gates active pixels into the FIFO and measures the resolution.
module dvi_capture_ctrl
    import dvi_pkg::*;
#(
    parameter logic VS_PULSE_LVL = VS_LVL_LOW,
    parameter int   DW           = DW_DEF,
    parameter int   CW           = CW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          pix_en,
    input  logic [DW-1:0] rgb_in,
    input  logic          de_in,
    input  logic          vsync_in,
    input  logic          start,
    input  logic          stop,
    input  logic          cont,
    input  logic          fifo_full,
    output logic          fifo_wr,
    output logic [DW-1:0] fifo_data,
    output logic          busy,
    output logic          frame_done,
    output logic          overflow,
    output logic [CW-1:0] width_meas,
    output logic [CW-1:0] height_meas,
    output logic [15:0]   frame_cnt
);

    localparam logic [CW-1:0] CNT_MAX = '1;

    cap_state_t    state;
    cap_state_t    state_nxt;
    logic          cont_q;
    logic [CW-1:0] line_cnt;
    logic [CW-1:0] pix_cnt;
    logic [CW-1:0] line_nxt;

    logic fs;
    logic fe;
    logic de_fall;
    logic pix_act;
    logic wr_en;
    logic done_en;
    logic ovf_set;
    logic arm;
    logic clr_cnt;
    logic line_inc;
    logic pix_inc;

    dvi_sync_edge #(
        .VS_PULSE_LVL(VS_PULSE_LVL)
    ) u_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .pix_en (pix_en),
        .vsync  (vsync_in),
        .de     (de_in),
        .fs     (fs),
        .fe     (fe),
        .de_fall(de_fall)
    );

    assign pix_act = pix_en && de_in;

    always_comb begin
        state_nxt = state;
        wr_en     = 1'b0;
        done_en   = 1'b0;
        ovf_set   = 1'b0;
        arm       = 1'b0;
        clr_cnt   = 1'b0;
        if (stop) begin
            state_nxt = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state_nxt = ARMED;
                        arm       = 1'b1;
                    end
                end
                ARMED: begin
                    if (fs) begin
                        state_nxt = CAPTURE;
                        clr_cnt   = 1'b1;
                    end
                end
                CAPTURE: begin
                    if (fe) begin
                        done_en   = 1'b1;
                        state_nxt = cont_q ? ARMED : IDLE;
                    end else if (pix_act) begin
                        if (fifo_full) begin
                            ovf_set   = 1'b1;
                            state_nxt = DROP;
                        end else begin
                            wr_en = 1'b1;
                        end
                    end
                end
                DROP: begin
                    if (fe) begin
                        state_nxt = cont_q ? ARMED : IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Counters only advance while a frame is being captured.
    assign line_inc = (state == CAPTURE) && de_fall;
    assign pix_inc  = (state == CAPTURE) && pix_act
                      && (line_cnt == '0);
    assign line_nxt = (line_inc && line_cnt != CNT_MAX)
                      ? line_cnt + 1'b1 : line_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            cont_q      <= 1'b0;
            line_cnt    <= '0;
            pix_cnt     <= '0;
            fifo_wr     <= 1'b0;
            fifo_data   <= '0;
            frame_done  <= 1'b0;
            overflow    <= 1'b0;
            width_meas  <= '0;
            height_meas <= '0;
            frame_cnt   <= '0;
        end else begin
            state      <= state_nxt;
            fifo_wr    <= wr_en;
            frame_done <= done_en;
            if (wr_en) begin
                fifo_data <= rgb_in;
            end
            if (arm) begin
                cont_q <= cont;
            end
            if (arm) begin
                overflow <= 1'b0;
            end else if (ovf_set) begin
                overflow <= 1'b1;
            end
            if (arm || clr_cnt) begin
                line_cnt <= '0;
                pix_cnt  <= '0;
            end else begin
                line_cnt <= line_nxt;
                if (pix_inc && pix_cnt != CNT_MAX) begin
                    pix_cnt <= pix_cnt + 1'b1;
                end
            end
            if (done_en) begin
                width_meas  <= pix_cnt;
                height_meas <= line_nxt;
                frame_cnt   <= frame_cnt + 16'd1;
            end
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_dvi_capture_ctrl.sv
// Directed bench for dvi_capture_ctrl with a frame-level reference
// model: expected pixel queue plus per-frame measurement bookkeeping.
module tb_dvi_capture_ctrl;

    localparam int DW  = 24;
    localparam int CW  = 6;
    localparam int SAT = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          pix_en = 1'b0;
    logic [DW-1:0] rgb_in = '0;
    logic          de_in = 1'b0;
    logic          vsync_in = 1'b0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          cont = 1'b0;
    logic          fifo_full = 1'b0;
    logic          fifo_wr;
    logic [DW-1:0] fifo_data;
    logic          busy;
    logic          frame_done;
    logic          overflow;
    logic [CW-1:0] width_meas;
    logic [CW-1:0] height_meas;
    logic [15:0]   frame_cnt;

    always #5 clk = ~clk;

    dvi_capture_ctrl #(
        .VS_PULSE_LVL(1'b0),
        .DW          (DW),
        .CW          (CW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pix_en     (pix_en),
        .rgb_in     (rgb_in),
        .de_in      (de_in),
        .vsync_in   (vsync_in),
        .start      (start),
        .stop       (stop),
        .cont       (cont),
        .fifo_full  (fifo_full),
        .fifo_wr    (fifo_wr),
        .fifo_data  (fifo_data),
        .busy       (busy),
        .frame_done (frame_done),
        .overflow   (overflow),
        .width_meas (width_meas),
        .height_meas(height_meas),
        .frame_cnt  (frame_cnt)
    );

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] exp_q[$];
    int wr_seen = 0;
    int done_seen = 0;
    int exp_cnt = 0;
    int exp_w = 0;
    int exp_h = 0;
    int exp_done = 0;
    bit exp_ovf = 0;
    bit pend = 0;
    int pend_w = 0;
    int pend_h = 0;
    int fid = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (frame_done) done_seen++;
        if (fifo_wr) wr_seen++;
        if (exp_q.size() == 0)
            chk("unexpected_wr", fifo_wr, 1'b0);
        else if (fifo_wr)
            chk("fifo_data", fifo_data, exp_q.pop_front());
    end

    task automatic chk_zero();
        chk("rst_fifo_wr", fifo_wr, 0);
        chk("rst_fifo_data", fifo_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_width", width_meas, 0);
        chk("rst_height", height_meas, 0);
        chk("rst_frame_cnt", frame_cnt, 0);
    endtask

    task automatic chk_model(input logic exp_busy);
        chk("frame_cnt", frame_cnt, exp_cnt);
        chk("width_meas", width_meas, exp_w);
        chk("height_meas", height_meas, exp_h);
        chk("overflow", overflow, exp_ovf);
        chk("done_pulses", done_seen, exp_done);
        chk("pending_writes", exp_q.size(), 0);
        chk("busy", busy, exp_busy);
    endtask

    task automatic apply_pend();
        if (pend) begin
            exp_cnt = (exp_cnt + 1) % 65536;
            exp_w = pend_w;
            exp_h = pend_h;
            exp_done++;
            pend = 0;
        end
    endtask

    // One sampled pixel followed by one idle clock full of junk.
    task automatic pix(input bit v, input bit d, input logic [DW-1:0] rgb,
                       input bit full = 0, input bit strt = 0,
                       input bit stp = 0, input bit cv = 0,
                       input bit rst = 0);
        pix_en = 1'b1;
        vsync_in = v;
        de_in = d;
        rgb_in = rgb;
        fifo_full = full;
        start = strt;
        stop = stp;
        cont = strt ? cv : 1'($urandom);
        rst_n = !rst;
        @(posedge clk);
        #1;
        if (stp) chk("busy_after_stop", busy, 0);
        if (rst) chk_zero();
        rst_n = 1'b1;
        pix_en = 1'b0;
        start = 1'b0;
        stop = 1'b0;
        vsync_in = 1'($urandom);
        de_in = 1'($urandom);
        rgb_in = DW'($urandom);
        fifo_full = 1'($urandom);
        cont = 1'($urandom);
        @(posedge clk);
        #1;
    endtask

    task automatic vpulse();
        apply_pend();
        pix(0, 0, '0);
        pix(0, 0, '0);
    endtask

    // st_line: -1 start on first pulse pixel, >=0 start at that line.
    // ab_kind: 1 stop, 2 reset at pixel (ab_l, ab_p).
    task automatic frame(input int w, input int h, input bit cap,
                         input int st_line, input bit st_cont,
                         input int full_l = -1, input int full_p = -1,
                         input int ab_l = -1, input int ab_p = -1,
                         input int ab_kind = 0);
        bit live;
        bit f;
        bit ab;
        bit s;
        logic [DW-1:0] px;
        fid++;
        live = cap;
        apply_pend();
        pix(0, 0, '0, 0, (st_line == -1), 0, st_cont);
        pix(0, 0, '0);
        pix(1, 0, '0);
        for (int l = 0; l < h; l++) begin
            for (int p = 0; p < w; p++) begin
                px = {fid[7:0], l[7:0], p[7:0]};
                f = live && (l == full_l) && (p == full_p);
                ab = (ab_kind != 0) && (l == ab_l) && (p == ab_p);
                s = (p == 0) && (l == st_line);
                if (f) exp_ovf = 1;
                if (f || ab) live = 0;
                if (live) exp_q.push_back(px);
                if (ab && ab_kind == 2) begin
                    exp_cnt = 0;
                    exp_w = 0;
                    exp_h = 0;
                    exp_ovf = 0;
                    pend = 0;
                end
                pix(1, 1, px, f, s, ab && ab_kind == 1, st_cont,
                    ab && ab_kind == 2);
            end
            pix(1, 0, '0);
            pix(1, 0, '0);
        end
        if (live) begin
            pend = 1;
            pend_w = (w > SAT) ? SAT : w;
            pend_h = (h > SAT) ? SAT : h;
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk_zero();

        frame(16, 12, 1, -1, 0);
        vpulse();
        chk_model(0);
        chk("lit_width", width_meas, 16);
        chk("lit_height", height_meas, 12);
        chk("lit_writes", wr_seen, 192);
        chk("lit_frame_cnt", frame_cnt, 1);

        frame(16, 12, 0, 6, 0);
        frame(16, 12, 1, -2, 0);
        vpulse();
        chk_model(0);
        chk("lit_writes2", wr_seen, 384);
        chk("lit_frame_cnt2", frame_cnt, 2);

        frame(20, 11, 1, -1, 1, 10, 5);
        frame(10, 7, 1, -2, 0);
        chk_model(1);
        chk("lit_ovf", overflow, 1);
        vpulse();
        chk_model(1);
        pix(0, 0, '0, 0, 0, 1);
        chk_model(0);
        chk("lit_frame_cnt3", frame_cnt, 3);

        exp_ovf = 0;
        frame(16, 12, 1, -1, 1);
        frame(8, 5, 1, -2, 0);
        frame(70, 66, 1, -2, 0);
        frame(16, 12, 1, -2, 0, -1, -1, 5, 3, 1);
        chk_model(0);
        chk("lit_sat_width", width_meas, 63);
        chk("lit_sat_height", height_meas, 63);
        vpulse();
        chk_model(0);
        chk("lit_frame_cnt6", frame_cnt, 6);

        frame(16, 12, 1, -1, 0, -1, -1, 3, 4, 2);
        vpulse();
        chk_model(0);
        frame(12, 9, 1, -1, 0);
        vpulse();
        chk_model(0);
        chk("lit_after_rst_cnt", frame_cnt, 1);

        pix(0, 0, '0, 0, 1, 1, 1);
        pix(1, 0, '0);
        chk("start_stop_busy", busy, 0);
        frame(8, 4, 0, -2, 0);
        vpulse();
        chk_model(0);
        pix(0, 0, '0, 0, 1, 0, 0);
        frame(8, 4, 1, 2, 1);
        vpulse();
        chk_model(0);
        frame(8, 4, 0, -2, 0);
        vpulse();
        chk_model(0);
        chk("lit_final_cnt", frame_cnt, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
